// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for alu_seq (feature macro: ALU_SEQ_MUL_EN)
package alu_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Bit positions inside the {V,N,Z,C} flags register
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Common ALUControl codes
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0101;
  localparam logic [3:0] AND = 4'b1000;
  localparam logic [3:0] OR  = 4'b1010;
  localparam logic [3:0] XOR = 4'b1100;
  localparam logic [3:0] NOT = 4'b1110;

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational ALU datapath: result, carry and overflow
module alu_core #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] result,
  output logic         c,
  output logic         v
);

  logic [N-1:0] y;
  logic [N:0]   sum_ext;

  // Second adder operand chosen by ALUControl[2:1]
  always_comb begin
    y = '0;
    case (ALUControl[2:1])
      2'b00:   y = '0;
      2'b01:   y = b;
      2'b10:   y = ~b;
      default: y = '1;
    endcase
  end

  // One extra bit keeps the carry-out; ALUControl[0] is the carry-in
  assign sum_ext = {1'b0, a} + {1'b0, y} + {{N{1'b0}}, ALUControl[0]};

  // Arithmetic when bit 3 is clear, bitwise logic (no C/V) when set
  always_comb begin
    result = sum_ext[N-1:0];
    c      = sum_ext[N];
    v      = (a[N-1] == y[N-1]) && (sum_ext[N-1] != a[N-1]);
    if (ALUControl[3]) begin
      c = 1'b0;
      v = 1'b0;
      case (ALUControl[2:1])
        2'b00:   result = a & b;
        2'b01:   result = a | b;
        2'b10:   result = a ^ b;
        default: result = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked registered ALU with NZCV flags; multiplier under ALU_SEQ_MUL_EN
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  input  logic         mul,
  input  logic         setflags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic [3:0]   ALUFlags
);

  state_t       state, state_next;
  logic         accept;
  logic         start_mul;
  logic         mul_done;
  logic         mul_sf;
  logic [N-1:0] prod;
  logic [N-1:0] core_result;
  logic         core_c, core_v;

  // Stall while multiplying or while an unconsumed result is pending
  assign in_ready = reset & (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  alu_core #(.N(N)) u_core (
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .result     (core_result),
    .c          (core_c),
    .v          (core_v)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_CNT_W = $clog2(N) + 1;

  logic [N-1:0]         mcand, mplier, acc, acc_sum;
  logic [MUL_CNT_W-1:0] cnt;

  assign start_mul = accept & mul;
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign mul_done  = (state == MUL) && (cnt == '0);
  assign prod      = acc_sum;

  // Shift-add iterations on operands latched at accept; counter runs N-1 down to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mul_sf <= 1'b0;
    end else if (start_mul) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= MUL_CNT_W'(N - 1);
      mul_sf <= setflags;
    end else if (state == MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - MUL_CNT_W'(1);
    end
  end
`else
  logic unused_mul;
  assign unused_mul = mul;
  assign start_mul  = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_sf     = 1'b0;
  assign prod       = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: enter MUL on a multiply accept, leave on its last iteration
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_mul) state_next = MUL;
      MUL:  if (mul_done)  state_next = IDLE;
    endcase
  end

  // Output register and flags: write on single-cycle accept or multiply completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Result    <= '0;
      ALUFlags  <= '0;
    end else if (accept && !start_mul) begin
      out_valid <= 1'b1;
      Result    <= core_result;
      if (setflags) begin
        ALUFlags[FLAG_V] <= core_v;
        ALUFlags[FLAG_N] <= core_result[N-1];
        ALUFlags[FLAG_Z] <= (core_result == '0);
        ALUFlags[FLAG_C] <= core_c;
      end
    end else if (mul_done) begin
      out_valid <= 1'b1;
      Result    <= prod;
      if (mul_sf) begin
        ALUFlags[FLAG_N] <= prod[N-1];
        ALUFlags[FLAG_Z] <= (prod == '0);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at N=8 (ALU_SEQ_MUL_EN selects multiply tests)
module tb_alu_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic [3:0]   ctrl;
  logic         mul;
  logic         setflags;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Result;
  logic [3:0]   ALUFlags;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] mflags;

  alu_seq #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .ALUControl (ctrl),
    .mul        (mul),
    .setflags   (setflags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  // Reference: returns {flags {V,N,Z,C}, result}
  function automatic logic [11:0] model_alu(input logic [7:0] ma, input logic [7:0] mb,
                                            input logic [3:0] mc, input logic sf,
                                            input logic [3:0] fin);
    int y, s, sa, sy, ss;
    logic [7:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    r = 8'h00;
    if (!mc[3]) begin
      case (mc[2:1])
        2'd0:    y = 0;
        2'd1:    y = int'(mb);
        2'd2:    y = 255 - int'(mb);
        default: y = 255;
      endcase
      s  = int'(ma) + y + int'(mc[0]);
      r  = 8'(s % 256);
      c  = (s >= 256);
      sa = (ma >= 8'd128) ? int'(ma) - 256 : int'(ma);
      sy = (y >= 128) ? y - 256 : y;
      ss = sa + sy + int'(mc[0]);
      v  = (ss > 127) || (ss < -128);
    end else begin
      case (mc[2:1])
        2'd0:    r = ma & mb;
        2'd1:    r = ma | mb;
        2'd2:    r = ma ^ mb;
        default: r = ~ma;
      endcase
    end
    return {(sf ? {v, r[7], (r == 8'h00), c} : fin), r};
  endfunction

  function automatic logic [11:0] model_mul(input logic [7:0] ma, input logic [7:0] mb,
                                            input logic sf, input logic [3:0] fin);
    int p;
    logic [7:0] r;
    p = int'(ma) * int'(mb);
    r = 8'(p % 256);
    return {(sf ? {fin[3], r[7], (r == 8'h00), fin[0]} : fin), r};
  endfunction

  task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic [3:0] dc,
                       input logic dm, input logic dsf, input logic dv);
    a = da; b = db; ctrl = dc; mul = dm; setflags = dsf; in_valid = dv;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (Result !== 8'h00) begin fails++; $display("FAIL reset_result: got %h expected 00", Result); end
    tests++; if (ALUFlags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", ALUFlags); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    reset = 1'b1;
    mflags = 4'h0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    drive(8'h7F, 8'h01, 4'b0010, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || Result !== 8'h80) begin fails++; $display("FAIL add_overflow_result: got v=%b %h expected v=1 80", out_valid, Result); end
    tests++; if (ALUFlags !== 4'b1100) begin fails++; $display("FAIL add_overflow_flags: got %b expected 1100", ALUFlags); end
    drive(8'h05, 8'h05, 4'b0101, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    tests++; if (Result !== 8'h00) begin fails++; $display("FAIL sub_zero_result: got %h expected 00", Result); end
    tests++; if (ALUFlags !== 4'b0011) begin fails++; $display("FAIL sub_zero_flags: got %b expected 0011", ALUFlags); end
    drive(8'hF0, 8'h0F, 4'b1000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    tests++; if (Result !== 8'h00) begin fails++; $display("FAIL and_nosf_result: got %h expected 00", Result); end
    tests++; if (ALUFlags !== 4'b0011) begin fails++; $display("FAIL and_nosf_flags: got %b expected 0011", ALUFlags); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL out_valid_drop: got %b expected 0", out_valid); end
    mflags = 4'b0011;
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic        v;
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      v = ($urandom % 4) != 0;
      drive(8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 1'($urandom), v);
`ifndef ALU_SEQ_MUL_EN
      mul = 1'($urandom);
`endif
      e = model_alu(a, b, ctrl, setflags, mflags);
      @(posedge clk); #1;
      tests++;
      if (out_valid !== v) begin
        fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, v);
      end else if (v && {ALUFlags, Result} !== e) begin
        fails++; $display("FAIL rand_result[%0d]: got flags=%b res=%h expected flags=%b res=%h", i, ALUFlags, Result, e[11:8], e[7:0]);
      end
      if (v) mflags = e[11:8];
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  oa[3], ob[3];
    logic [3:0]  oc[3];
    logic [11:0] q[$];
    logic [11:0] e;
    int idx = 0;
    int got = 0;
    oc[0] = 4'b0010; oc[1] = 4'b1100; oc[2] = 4'b1010;
    for (int i = 0; i < 3; i++) begin oa[i] = 8'($urandom); ob[i] = 8'($urandom); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 4);
      if (idx < 3) drive(oa[idx], ob[idx], oc[idx], 1'b0, 1'b1, 1'b1);
      else in_valid = 1'b0;
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL btb_stall_in_ready[%0d]: got %b expected 0", cyc, in_ready); end
        tests++;
        if (q.size() == 0 || out_valid !== 1'b1 || {ALUFlags, Result} !== q[0]) begin
          fails++; $display("FAIL btb_hold[%0d]: got v=%b flags=%b res=%h", cyc, out_valid, ALUFlags, Result);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL btb_extra_output: got res=%h expected none", Result);
        end else begin
          e = q.pop_front();
          got++;
          if ({ALUFlags, Result} !== e) begin
            fails++; $display("FAIL btb_order[%0d]: got flags=%b res=%h expected flags=%b res=%h", got, ALUFlags, Result, e[11:8], e[7:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model_alu(a, b, ctrl, 1'b1, mflags);
        mflags = e[11:8];
        q.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
    end
    tests++; if (idx != 3 || got != 3) begin fails++; $display("FAIL btb_count: got accepted=%0d delivered=%0d expected 3/3", idx, got); end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul();
    logic [7:0]  ta[6], tb[6];
    logic        ts[6];
    logic [11:0] e;
    int cycles;
    ta[0] = 8'd13; tb[0] = 8'd11; ts[0] = 1'b1;
    ta[1] = 8'h10; tb[1] = 8'h10; ts[1] = 1'b1;
    for (int i = 2; i < 6; i++) begin ta[i] = 8'($urandom); tb[i] = 8'($urandom); ts[i] = 1'($urandom); end
    out_ready = 1'b1;
    drive(8'h05, 8'h05, 4'b0101, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    mflags = model_alu(8'h05, 8'h05, 4'b0101, 1'b1, mflags) >> 8;
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tb[i], 4'($urandom), 1'b1, ts[i], 1'b1);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mul_accept_ready[%0d]: got %b expected 1", i, in_ready); end
      e = model_mul(ta[i], tb[i], ts[i], mflags);
      @(posedge clk); #1;
      drive(8'($urandom), 8'($urandom), 4'($urandom), 1'b0, ~ts[i], 1'b0);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 20) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mul_busy_in_ready[%0d.%0d]: got %b expected 0", i, cycles, in_ready); end
        @(posedge clk); #1;
        cycles++;
      end
      tests++; if (cycles != N) begin fails++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, cycles, N); end
      tests++;
      if ({ALUFlags, Result} !== e) begin
        fails++; $display("FAIL mul_result[%0d]: got flags=%b res=%h expected flags=%b res=%h", i, ALUFlags, Result, e[11:8], e[7:0]);
      end
      mflags = e[11:8];
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_mul_ignored();
    out_ready = 1'b1;
    drive(8'd3, 8'd4, 4'b0010, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || Result !== 8'h07) begin fails++; $display("FAIL nomul_add: got v=%b res=%h expected v=1 07", out_valid, Result); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_op();
    out_ready = 1'b1;
    drive(8'h05, 8'h05, 4'b0101, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
`ifdef ALU_SEQ_MUL_EN
    drive(8'd13, 8'd11, 4'b0010, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`else
    in_valid = 1'b0;
`endif
    #2 reset = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (ALUFlags !== 4'h0) begin fails++; $display("FAIL async_reset_flags: got %b expected 0000", ALUFlags); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL async_reset_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    mflags = 4'h0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    drive(8'h21, 8'h12, 4'b0010, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || Result !== 8'h33 || ALUFlags !== 4'b0000) begin
      fails++; $display("FAIL post_reset_add: got v=%b flags=%b res=%h expected v=1 flags=0000 res=33", out_valid, ALUFlags, Result);
    end
    repeat (10) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL discarded_mul_emerged: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
`else
    test_mul_ignored();
`endif
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Registers every result and keeps a persistent NZCV flags register with per-operation set-flags control.
- Adds a multi-cycle shift-add unsigned multiply.
- Sits between the decode/issue stage and writeback; either side may stall through valid/ready.

Parameters:
N, 32, operand and result width in bits (N >= 4).
MUL_CNT_W, $clog2(N)+1, width of the multiply iteration counter (derived; do not override).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (low = reset asserted)
in_valid  in  1  operation presented
in_ready  out  1  block accepts an operation this cycle
a  in  N  operand A
b  in  N  operand B
ALUControl  in  4  operation code, same encoding as the combinational ALU
mul  in  1  1 = unsigned multiply (low N bits of a*b); ALUControl is ignored
setflags  in  1  1 = update the flags register when this operation completes
out_valid  out  1  Result valid
out_ready  in  1  consumer takes Result this cycle
Result  out  N  registered result
ALUFlags  out  4  flags register {V,N,Z,C}

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; out_valid=0, Result=0, ALUFlags=0, in_ready=0 while reset is low. Any multiply in progress is discarded.
- Accept: the operation transfers when in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
- ALUControl decode:
  - 0??: sum = a + y + ALUControl[0], where y is selected by ALUControl[2:1]: 00 -> 0, 01 -> b, 10 -> ~b, 11 -> all ones.
  - 1000: a&b. 1010: a|b. 1100: a^b. 1110: ~a.
  - Bit 0 is ignored for logic ops.
- Single-cycle op: Result and out_valid=1 are registered on the cycle after accept (latency 1). Back-to-back accepts give one result per cycle while out_ready=1.
- Flags are computed on the result being written and loaded into ALUFlags on that same edge, only if setflags was 1 at accept.
  - N = Result[N-1]; Z = (Result==0).
  - C = carry-out of the sum for arithmetic ops, 0 for logic ops.
  - V = arith & (a[N-1]==y[N-1]) & (sum[N-1]!=a[N-1]), 0 for logic ops.
  - The V expression is normative; do not use the buggy '+'-form.
- Multiply FSM: IDLE -> MUL on accept with mul=1. Latch a, b and setflags. Run N shift-add iterations, one per cycle; the counter counts N-1 down to 0.
  - MUL -> IDLE on the final iteration.
  - On that edge, Result = low N bits of the product and out_valid=1.
  - Total latency is N cycles from accept to out_valid.
  - Flags: N and Z update as above. C and V are preserved. All flags are held when setflags=0.
- Output hold: while out_valid & ~out_ready, Result and out_valid hold and in_ready=0. When out_ready=1 and no new result is written, out_valid drops next cycle.
- Simultaneous accept and consume: a new result overwrites the consumed one in the same cycle, with no bubble.
- Wrap-around: arithmetic wraps modulo 2^N. Only the low N bits of a multiply are kept; no overflow flag is raised.
- Inputs are sampled only at accept; changes in a/b during MUL have no effect.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: the multiplier and MUL state exist as described.
- Not defined: no multiplier logic, and the FSM is IDLE-only. The mul input is ignored and the op executes as a single-cycle op per ALUControl.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum {IDLE, MUL};
  - flag index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3;
  - localparams for ALUControl codes (ADD=4'b0010, SUB=4'b0101, AND=4'b1000, OR=4'b1010, XOR=4'b1100, NOT=4'b1110).
- One sub-module, alu_core: purely combinational, taking a, b, ALUControl and producing result, C and V. alu_seq registers its outputs and owns the FSM, handshake and flags register.

Test Plan (N=8):
- ADD 0x7F+0x01, setflags=1, out_ready=1 -> next cycle Result=0x80, ALUFlags={V=1,N=1,Z=0,C=0}.
- SUB 0x05-0x05 (ALUControl=0101), setflags=1 -> Result=0x00, flags Z=1, C=1, V=0, N=0. Then AND 0xF0&0x0F with setflags=0 -> Result=0x00, flags unchanged.
- MUL 13*11 with ALU_SEQ_MUL_EN, prior C=1 -> in_ready=0 for 8 cycles, then Result=0x8F (143), N=1, Z=0, C=1 preserved. Repeat 0x10*0x10 -> Result=0x00, Z=1.
- Back-to-back ADD/XOR/OR with out_ready held 0 for 3 cycles -> first Result held stable, in_ready=0, no ops lost, and the three results emerge in order after out_ready=1.
- Assert reset low mid-MUL (cycle 4) -> out_valid=0, ALUFlags=0 immediately; after release, in_ready=1 and a new ADD completes normally.
- Without ALU_SEQ_MUL_EN: mul=1, ALUControl=0010, a=3, b=4 -> 1-cycle latency, Result=0x07.
